// File: rtl/decoder_proj_pkg.sv
// Shared decode constants: segment table, mode encodings, counter width.
// Pure definitions; no logic, no latency, no backpressure.
package decoder_proj_pkg;

    localparam logic MODE_HEX    = 1'b0;
    localparam logic MODE_ONEHOT = 1'b1;

    localparam int LOAD_CNT_W = 8;

    // Active-high {g,f,e,d,c,b,a}, indexed by nibble value 0..F.
    localparam logic [0:15][6:0] SEG_TABLE = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/decoder_proj_core.sv
// Combinational nibble decode: hex 7-segment or 3-to-8 one-hot.
// Zero latency; no backpressure (pure function of inputs).
module decoder_proj_core
    import decoder_proj_pkg::*;
(
    input  logic       mode,
    input  logic [3:0] nibble,
    output logic [7:0] pattern
);

    always_comb begin
        pattern = '0;
        if (mode == MODE_HEX) begin
            pattern = {1'b0, SEG_TABLE[nibble]};
        end else begin
            pattern = 8'(1) << nibble[2:0];
        end
    end

endmodule

// File: rtl/decoder_proj_formal.sv
// Registered decoder with saturating load counter, sticky property and cover flags.
// One-cycle io_out latency; no backpressure, every enabled load is accepted.
module decoder_proj_formal
    import decoder_proj_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            io_in,
    output logic [7:0]            io_out,
    output logic                  out_valid,
    output logic [LOAD_CNT_W-1:0] load_cnt,
    output logic                  prop_fail,
    output logic                  cov_hex_f,
    output logic                  cov_onehot_msb
);

    logic [3:0] nibble;
    logic       load;
    logic       mode;
    logic       enable;
    logic [7:0] decoded;
    logic       mode_q;
    logic       is_onehot;
    logic       prop_bad;
    logic       hit_hex_f;
    logic       hit_onehot_msb;

    assign nibble = io_in[3:0];
    assign load   = io_in[4];
    assign mode   = io_in[5];
    assign enable = io_in[6];

    decoder_proj_core u_core (
        .mode    (mode),
        .nibble  (nibble),
        .pattern (decoded)
    );

    // Properties and covers observe the registered state, so flags land one edge later.
    assign is_onehot      = (io_out != 8'h00) && ((io_out & (io_out - 8'h01)) == 8'h00);
    assign prop_bad       = (out_valid && (mode_q == MODE_ONEHOT) && !is_onehot) ||
                            (!out_valid && (io_out != 8'h00));
    assign hit_hex_f      = out_valid && (mode_q == MODE_HEX)    && (io_out == 8'h71);
    assign hit_onehot_msb = out_valid && (mode_q == MODE_ONEHOT) && (io_out == 8'h80);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io_out         <= '0;
            out_valid      <= 1'b0;
            load_cnt       <= '0;
            mode_q         <= MODE_HEX;
            prop_fail      <= 1'b0;
            cov_hex_f      <= 1'b0;
            cov_onehot_msb <= 1'b0;
        end else begin
            if (!enable) begin
                io_out    <= '0;
                out_valid <= 1'b0;
            end else if (load) begin
                io_out    <= decoded;
                out_valid <= 1'b1;
                mode_q    <= mode;
                if (load_cnt != '1) begin
                    load_cnt <= load_cnt + LOAD_CNT_W'(1);
                end
            end
            if (prop_bad) begin
                prop_fail <= 1'b1;
            end
            if (hit_hex_f) begin
                cov_hex_f <= 1'b1;
            end
            if (hit_onehot_msb) begin
                cov_onehot_msb <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decoder_proj_formal.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_decoder_proj_formal;

    logic       clk;
    logic       rst_n;
    logic [6:0] io_in;
    logic [7:0] io_out;
    logic       out_valid;
    logic [7:0] load_cnt;
    logic       prop_fail;
    logic       cov_hex_f;
    logic       cov_onehot_msb;

    int checks;
    int errors;

    decoder_proj_formal dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .io_in          (io_in),
        .io_out         (io_out),
        .out_valid      (out_valid),
        .load_cnt       (load_cnt),
        .prop_fail      (prop_fail),
        .cov_hex_f      (cov_hex_f),
        .cov_onehot_msb (cov_onehot_msb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0] seg_ref [16];
    logic [7:0] m_out;
    logic       m_vld;
    logic       m_mode;
    int         m_cnt;
    logic       m_pf;
    logic       m_hex;
    logic       m_msb;

    function automatic logic [7:0] ref_dec(input logic m, input logic [3:0] n);
        int k;
        k = int'(n) % 8;
        if (m) return 8'(1 << k);
        return seg_ref[n];
    endfunction

    task automatic model_update(input logic r, input logic [6:0] v);
        logic pf_c, hex_c, msb_c;
        if (!r) begin
            m_out = 0; m_vld = 0; m_mode = 0; m_cnt = 0;
            m_pf = 0; m_hex = 0; m_msb = 0;
        end else begin
            pf_c  = (m_vld && m_mode && ($countones(m_out) != 1)) || (!m_vld && m_out != 0);
            hex_c = m_vld && !m_mode && (m_out == 8'h71);
            msb_c = m_vld && m_mode && (m_out == 8'h80);
            if (!v[6]) begin
                m_out = 0;
                m_vld = 0;
            end else if (v[4]) begin
                m_out  = ref_dec(v[5], v[3:0]);
                m_vld  = 1;
                m_mode = v[5];
                m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
            m_pf  = m_pf  | pf_c;
            m_hex = m_hex | hex_c;
            m_msb = m_msb | msb_c;
        end
    endtask

    task automatic step(input logic r, input logic [6:0] v);
        @(negedge clk);
        rst_n = r;
        io_in = v;
        @(posedge clk);
        model_update(r, v);
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 7'b1110011);
        step(1'b1, 7'b1010101);
        step(1'b0, 7'b1111111);
        checks++; if (io_out !== 8'h00) begin errors++; $display("FAIL reset_io_out got %h want 00", io_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (load_cnt !== 8'd0) begin errors++; $display("FAIL reset_load_cnt got %0d want 0", load_cnt); end
        checks++; if (prop_fail !== 1'b0) begin errors++; $display("FAIL reset_prop_fail got %b want 0", prop_fail); end
        checks++; if (cov_hex_f !== 1'b0) begin errors++; $display("FAIL reset_cov_hex_f got %b want 0", cov_hex_f); end
        checks++; if (cov_onehot_msb !== 1'b0) begin errors++; $display("FAIL reset_cov_msb got %b want 0", cov_onehot_msb); end
    endtask

    task automatic test_onehot_basic;
        step(1'b0, 7'b0000000);
        step(1'b1, 7'b1110110);
        checks++; if (io_out !== 8'h40) begin errors++; $display("FAIL onehot6_io_out got %h want 40", io_out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL onehot6_valid got %b want 1", out_valid); end
        checks++; if (load_cnt !== 8'd1) begin errors++; $display("FAIL onehot6_cnt got %0d want 1", load_cnt); end
        checks++; if (prop_fail !== 1'b0) begin errors++; $display("FAIL onehot6_prop got %b want 0", prop_fail); end
    endtask

    task automatic test_hex_f;
        step(1'b0, 7'b0000000);
        step(1'b1, 7'b1011111);
        checks++; if (io_out !== 8'h71) begin errors++; $display("FAIL hexF_io_out got %h want 71", io_out); end
        checks++; if (cov_hex_f !== 1'b0) begin errors++; $display("FAIL hexF_cov_early got %b want 0", cov_hex_f); end
        step(1'b1, 7'b1000000);
        checks++; if (cov_hex_f !== 1'b1) begin errors++; $display("FAIL hexF_cov got %b want 1", cov_hex_f); end
        checks++; if (io_out !== 8'h71) begin errors++; $display("FAIL hexF_hold got %h want 71", io_out); end
        // Each hex digit in turn
        for (int n = 0; n < 16; n++) begin
            step(1'b1, {3'b101, 4'(n)});
            checks++;
            if (io_out !== seg_ref[n]) begin errors++; $display("FAIL hex_digit_%0d got %h want %h", n, io_out, seg_ref[n]); end
        end
    endtask

    task automatic test_onehot_msb;
        step(1'b0, 7'b0000000);
        step(1'b1, 7'b1111111);
        checks++; if (io_out !== 8'h80) begin errors++; $display("FAIL msb_io_out got %h want 80", io_out); end
        step(1'b1, 7'b1100000);
        checks++; if (cov_onehot_msb !== 1'b1) begin errors++; $display("FAIL msb_cov got %b want 1", cov_onehot_msb); end
        step(1'b1, 7'b1110111);
        checks++; if (io_out !== 8'h80) begin errors++; $display("FAIL msb_nib3_ignored got %h want 80", io_out); end
        checks++; if (load_cnt !== 8'd2) begin errors++; $display("FAIL msb_cnt got %0d want 2", load_cnt); end
    endtask

    task automatic test_disable;
        step(1'b0, 7'b0000000);
        step(1'b1, 7'b1010011);
        step(1'b1, 7'b0011010);
        checks++; if (io_out !== 8'h00) begin errors++; $display("FAIL dis_io_out got %h want 00", io_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dis_valid got %b want 0", out_valid); end
        checks++; if (load_cnt !== 8'd1) begin errors++; $display("FAIL dis_cnt got %0d want 1", load_cnt); end
        step(1'b1, 7'b0000000);
        checks++; if (prop_fail !== 1'b0) begin errors++; $display("FAIL dis_prop got %b want 0", prop_fail); end
    endtask

    task automatic test_saturate;
        step(1'b0, 7'b0000000);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, {1'b1, 1'($urandom), 1'b1, 4'($urandom)});
            if (i == 254 || i == 299) begin
                checks++;
                if (load_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL sat_cnt_%0d got %0d want %0d", i, load_cnt, m_cnt); end
            end
        end
        checks++; if (load_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got %0d want 255", load_cnt); end
    endtask

    task automatic test_random;
        logic r;
        logic [6:0] v;
        step(1'b0, 7'b0000000);
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 19) != 0);
            v = 7'($urandom);
            step(r, v);
            checks++;
            if (io_out !== m_out || out_valid !== m_vld || load_cnt !== 8'(m_cnt) ||
                prop_fail !== m_pf || cov_hex_f !== m_hex || cov_onehot_msb !== m_msb) begin
                errors++;
                $display("FAIL rand_%0d got out=%h v=%b c=%0d pf=%b h=%b m=%b want out=%h v=%b c=%0d pf=%b h=%b m=%b",
                         i, io_out, out_valid, load_cnt, prop_fail, cov_hex_f, cov_onehot_msb,
                         m_out, m_vld, m_cnt, m_pf, m_hex, m_msb);
            end
        end
    endtask

    initial begin
        seg_ref = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        io_in  = 7'd0;
        m_out = 0; m_vld = 0; m_mode = 0; m_cnt = 0; m_pf = 0; m_hex = 0; m_msb = 0;
        step(1'b0, 7'b0000000);
        test_reset;
        test_onehot_basic;
        test_hex_f;
        test_onehot_msb;
        test_disable;
        test_saturate;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
